// File: rtl/vending_core_pkg.sv
// Shared definitions for the vending core: FSM states and the coin value table.
package vending_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } state_e;

  localparam int NUM_COINS = 3;
  localparam int COIN_VALUE [NUM_COINS] = '{5, 10, 50};

  function automatic int coin_value(input int k);
    return COIN_VALUE[k];
  endfunction

  // Lowest set bit wins when several coins arrive in one cycle.
  function automatic int lowest_coin(input logic [NUM_COINS-1:0] c);
    int idx;
    idx = 0;
    for (int k = NUM_COINS - 1; k >= 0; k--) begin
      if (c[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/vend_change_timer.sv
// Free-running tick counter for the change return: clears while idle,
// counts 0..TICKS-1 while enabled and flags the terminal count.
module vend_change_timer #(
  parameter int TICKS = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = en && (cnt_q == CNT_W'(TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vending_core.sv
// Vending machine controller: credit accumulation, product selection with
// per-item stock, one-cycle dispense and paced change return.
module vending_core
  import vending_core_pkg::*;
#(
  parameter int NUM_ITEMS    = 4,
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 100,
  parameter int STOCK_W      = 4,
  parameter int INIT_STOCK   = 9,
  parameter int CHANGE_UNIT  = 5,
  parameter int RETURN_TICKS = 100000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_COINS-1:0]          coin,
  input  logic                          sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0]  sel_idx,
  input  logic                          cancel,
  input  logic [NUM_ITEMS*CREDIT_W-1:0] price_tbl,
  input  logic                          refill,
  output logic [CREDIT_W-1:0]           credit,
  output logic [NUM_ITEMS-1:0]          avail,
  output logic                          disp_valid,
  output logic [$clog2(NUM_ITEMS)-1:0]  disp_idx,
  output logic                          change_pulse,
  output logic [CREDIT_W-1:0]           change_amt,
  output logic                          coin_reject,
  output logic                          sel_deny,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_ITEMS);
  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

  function automatic logic [CREDIT_W-1:0] change_step(input logic [CREDIT_W-1:0] c);
    return (c < CREDIT_W'(CHANGE_UNIT)) ? c : CREDIT_W'(CHANGE_UNIT);
  endfunction

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
  logic [IDX_W-1:0]    disp_idx_q, disp_idx_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                change_pulse_q, change_pulse_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_deny_q, sel_deny_d;

  logic [CREDIT_W-1:0] price [NUM_ITEMS];
  logic [CREDIT_W-1:0] sel_price;
  logic [SUM_W-1:0]    coin_sum;
  logic [CREDIT_W-1:0] step_amt;
  logic                sel_in_range;
  logic                tick_tc;

  vend_change_timer #(
    .TICKS (RETURN_TICKS)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_q != ST_CHANGE),
    .en  (state_q == ST_CHANGE),
    .tc  (tick_tc)
  );

  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      price[i] = price_tbl[i*CREDIT_W +: CREDIT_W];
    end
  end

  assign sel_in_range = {1'b0, sel_idx} < (IDX_W + 1)'(NUM_ITEMS);

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    disp_idx_d     = disp_idx_q;
    change_amt_d   = change_amt_q;
    change_pulse_d = 1'b0;
    coin_reject_d  = 1'b0;
    sel_deny_d     = 1'b0;
    sel_price      = price[sel_idx];
    coin_sum       = {1'b0, credit_q} + SUM_W'(coin_value(lowest_coin(coin)));
    step_amt       = change_step(credit_q);

    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          if (credit_q != '0) state_d = ST_CHANGE;
        end else if (sel_valid) begin
          if (sel_in_range && credit_q >= sel_price && stock_q[sel_idx] != '0) begin
            credit_d         = credit_q - sel_price;
            stock_d[sel_idx] = stock_q[sel_idx] - 1'b1;
            disp_idx_d       = sel_idx;
            state_d          = ST_DISPENSE;
          end else begin
            sel_deny_d = 1'b1;
          end
        end else if (coin != '0) begin
          // Overflowing coins are bounced, never clamped.
          if (coin_sum <= SUM_W'(MAX_CREDIT)) credit_d = coin_sum[CREDIT_W-1:0];
          else                                coin_reject_d = 1'b1;
        end
      end
      ST_DISPENSE: begin
        state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if (tick_tc) begin
          credit_d       = credit_q - step_amt;
          change_pulse_d = 1'b1;
          change_amt_d   = step_amt;
          if (credit_q == step_amt) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Refill overrides any decrement made this cycle.
    if (refill) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      disp_idx_q     <= '0;
      change_amt_q   <= '0;
      change_pulse_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      sel_deny_q     <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      disp_idx_q     <= disp_idx_d;
      change_amt_q   <= change_amt_d;
      change_pulse_q <= change_pulse_d;
      coin_reject_q  <= coin_reject_d;
      sel_deny_q     <= sel_deny_d;
      stock_q        <= stock_d;
    end
  end

  always_comb begin
    avail = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      avail[i] = (state_q == ST_IDLE) && (credit_q >= price[i]) && (stock_q[i] != '0);
    end
  end

  assign credit       = credit_q;
  assign disp_valid   = (state_q == ST_DISPENSE);
  assign disp_idx     = disp_idx_q;
  assign change_pulse = change_pulse_q;
  assign change_amt   = change_amt_q;
  assign coin_reject  = coin_reject_q;
  assign sel_deny     = sel_deny_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vending_core.sv
// Bench for vending_core: transaction-level machine model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_vending_core;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int MAXC = 100;
  localparam int SW   = 4;
  localparam int INIT = 9;
  localparam int UNIT = 5;
  localparam int RT   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    coin = '0;
  logic          sel_valid = 1'b0;
  logic [1:0]    sel_idx = '0;
  logic          cancel = 1'b0;
  logic [N*CW-1:0] price_tbl = '0;
  logic          refill = 1'b0;
  logic [CW-1:0] credit;
  logic [N-1:0]  avail;
  logic          disp_valid;
  logic [1:0]    disp_idx;
  logic          change_pulse;
  logic [CW-1:0] change_amt;
  logic          coin_reject;
  logic          sel_deny;
  logic          busy;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  vending_core #(
    .NUM_ITEMS(N), .CREDIT_W(CW), .MAX_CREDIT(MAXC), .STOCK_W(SW),
    .INIT_STOCK(INIT), .CHANGE_UNIT(UNIT), .RETURN_TICKS(RT)
  ) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .sel_idx(sel_idx),
    .cancel(cancel), .price_tbl(price_tbl), .refill(refill), .credit(credit),
    .avail(avail), .disp_valid(disp_valid), .disp_idx(disp_idx),
    .change_pulse(change_pulse), .change_amt(change_amt),
    .coin_reject(coin_reject), .sel_deny(sel_deny), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int price_of(input int i);
    return int'(price_tbl[i*CW +: CW]);
  endfunction

  // Model: mode 0 = waiting for customer, 1 = handing out product, 2 = refunding.
  int m_credit, m_mode, m_wait, m_disp_idx, m_amt, m_v, m_i;
  bit m_pulse, m_rej, m_deny;
  int m_stock [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_credit = 0; m_mode = 0; m_wait = 0; m_disp_idx = 0; m_amt = 0;
      m_pulse = 0; m_rej = 0; m_deny = 0;
      for (int i = 0; i < N; i++) m_stock[i] = INIT;
    end else begin
      m_pulse = 0; m_rej = 0; m_deny = 0;
      case (m_mode)
        0: begin
          if (cancel) begin
            if (m_credit > 0) begin m_mode = 2; m_wait = RT; end
          end else if (sel_valid) begin
            m_i = int'(sel_idx);
            if (m_i < N && m_credit >= price_of(m_i) && m_stock[m_i] > 0) begin
              m_credit -= price_of(m_i);
              m_stock[m_i]--;
              m_disp_idx = m_i;
              m_mode = 1;
            end else m_deny = 1;
          end else if (coin != 3'b000) begin
            m_v = coin[0] ? 5 : (coin[1] ? 10 : 50);
            if (m_credit + m_v <= MAXC) m_credit += m_v;
            else m_rej = 1;
          end
        end
        1: begin
          if (m_credit > 0) begin m_mode = 2; m_wait = RT; end
          else m_mode = 0;
        end
        default: begin
          m_wait--;
          if (m_wait == 0) begin
            m_amt = (m_credit < UNIT) ? m_credit : UNIT;
            m_credit -= m_amt;
            m_pulse = 1;
            m_wait = RT;
            if (m_credit == 0) m_mode = 0;
          end
        end
      endcase
      if (refill) for (int i = 0; i < N; i++) m_stock[i] = (1 << SW) - 1;
    end
  end

  function automatic logic [N-1:0] model_avail();
    logic [N-1:0] a;
    for (int i = 0; i < N; i++)
      a[i] = (m_mode == 0) && (m_credit >= price_of(i)) && (m_stock[i] > 0);
    return a;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("credit", credit, m_credit);
      check("busy", busy, m_mode != 0);
      check("disp_valid", disp_valid, m_mode == 1);
      if (m_mode == 1) check("disp_idx", disp_idx, m_disp_idx);
      check("change_pulse", change_pulse, m_pulse);
      if (m_pulse) check("change_amt", change_amt, m_amt);
      check("coin_reject", coin_reject, m_rej);
      check("sel_deny", sel_deny, m_deny);
      check("avail", avail, model_avail());
    end
  end

  task automatic step(input logic [2:0] c, input logic sv, input logic [1:0] si,
                      input logic ca, input logic rf);
    coin = c; sel_valid = sv; sel_idx = si; cancel = ca; refill = rf;
    @(posedge clk); #1;
    coin = '0; sel_valid = 1'b0; cancel = 1'b0; refill = 1'b0;
  endtask

  task automatic idle_step();
    step(3'b000, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin idle_step(); n++; end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic set_prices(input int p0, input int p1, input int p2, input int p3);
    price_tbl = {CW'(p3), CW'(p2), CW'(p1), CW'(p0)};
  endtask

  int pulses, first_k, last_k, gap_bad;

  initial begin
    set_prices(75, 20, 30, 10);
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_avail", avail, 0);
    check("rst_change_amt", change_amt, 0);
    rst = 1'b0;

    // 50+10+10+5 buys the 75 item exactly; no change expected.
    step(3'b100, 0, 0, 0, 0);
    step(3'b010, 0, 0, 0, 0);
    step(3'b010, 0, 0, 0, 0);
    step(3'b001, 0, 0, 0, 0);
    check("coins_75", credit, 75);
    step(3'b000, 1, 2'd0, 0, 0);
    check("disp_valid_item0", disp_valid, 1);
    check("disp_idx_item0", disp_idx, 0);
    check("credit_after_buy", credit, 0);
    idle_step();
    check("disp_one_cycle", disp_valid, 0);
    check("no_change_after_exact", busy, 0);

    // Drain item 2 for free so its stock reaches zero.
    set_prices(75, 20, 0, 10);
    for (int k = 0; k < INIT; k++) begin
      step(3'b000, 1, 2'd2, 0, 0);
      idle_step();
    end
    set_prices(75, 20, 30, 10);

    step(3'b100, 0, 0, 0, 0);
    step(3'b100, 0, 0, 0, 0);
    check("credit_100", credit, 100);
    step(3'b001, 0, 0, 0, 0);
    check("reject_over_max", coin_reject, 1);
    check("credit_stays_100", credit, 100);

    step(3'b000, 1, 2'd2, 0, 0);
    check("deny_no_stock", sel_deny, 1);
    check("avail2_empty", avail[2], 0);
    check("credit_after_deny", credit, 100);
    step(3'b000, 0, 0, 0, 1);
    check("avail2_refilled", avail[2], 1);
    step(3'b000, 1, 2'd2, 0, 0);
    check("disp_after_refill", disp_valid, 1);
    check("disp_idx_item2", disp_idx, 2);
    check("credit_70", credit, 70);
    wait_idle(200);
    check("refund_done", credit, 0);

    // Cancel with 20: four 5-unit pulses spaced RT cycles apart.
    step(3'b010, 0, 0, 0, 0);
    step(3'b010, 0, 0, 0, 0);
    step(3'b000, 0, 0, 1, 0);
    pulses = 0; first_k = 0; last_k = 0; gap_bad = 0;
    for (int k = 1; k <= 40 && busy; k++) begin
      idle_step();
      if (change_pulse) begin
        pulses++;
        check("cancel_amt", change_amt, 5);
        if (pulses == 1) first_k = k;
        else if (k - last_k != RT) gap_bad++;
        last_k = k;
      end
    end
    check("cancel_pulses", pulses, 4);
    check("cancel_first_pulse", first_k, 4);
    check("cancel_gap_errors", gap_bad, 0);
    check("cancel_busy_low", busy, 0);

    // cancel + select + coin together: refund wins, coin is dropped.
    step(3'b010, 0, 0, 0, 0);
    step(3'b010, 0, 0, 0, 0);
    step(3'b010, 0, 0, 0, 0);
    check("credit_30", credit, 30);
    step(3'b001, 1, 2'd3, 1, 0);
    check("combo_busy", busy, 1);
    check("combo_no_disp", disp_valid, 0);
    check("combo_credit", credit, 30);
    check("combo_no_deny", sel_deny, 0);
    wait_idle(100);
    check("combo_coin_lost", credit, 0);

    // Reset in the middle of a refund discards the remainder.
    step(3'b010, 0, 0, 0, 0);
    step(3'b001, 0, 0, 0, 0);
    step(3'b000, 0, 0, 1, 0);
    for (int k = 0; k < 10 && !change_pulse; k++) idle_step();
    check("partial_refund", credit, 10);
    rst = 1'b1;
    #1;
    check("rst_mid_credit", credit, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pulse", change_pulse, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      idle_step();
      if (change_pulse) pulses++;
    end
    check("no_pulse_after_rst", pulses, 0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [2:0] c;
      logic sv, ca, rf;
      if (k % 250 == 0)
        set_prices($urandom_range(0, 100), $urandom_range(0, 60),
                   $urandom_range(0, 40), $urandom_range(0, 20));
      c  = ($urandom_range(0, 99) < 40) ? 3'($urandom_range(1, 7)) : 3'b000;
      sv = ($urandom_range(0, 99) < 15);
      ca = ($urandom_range(0, 99) < 3);
      rf = ($urandom_range(0, 99) < 1);
      if (k == 1500) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      step(c, sv, 2'($urandom_range(0, 3)), ca, rf);
    end
    wait_idle(200);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vending_core.md
VENDING_CORE -- requirements
Module: vending_core

Interface
REQ-001 The block SHALL have parameter NUM_ITEMS, default 4: number of selectable products.
REQ-002 The block SHALL have parameter CREDIT_W, default 8: credit and price width in bits.
REQ-003 The block SHALL have parameter MAX_CREDIT, default 100: credit ceiling.
REQ-004 The block SHALL have parameter STOCK_W, default 4, and parameter INIT_STOCK, default 9: per-item stock width and stock value at reset.
REQ-005 The block SHALL have parameter CHANGE_UNIT, default 5: amount returned per change step.
REQ-006 The block SHALL have parameter RETURN_TICKS, default 100000000: clk cycles between change steps.
REQ-007 The block SHALL have port clk, input, 1 bit: clock.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 The block SHALL have port coin, input, 3 bits: one-cycle pulses; bit k means a coin of value COIN_VALUE[k] was inserted.
REQ-010 The block SHALL have port sel_valid, input, 1 bit, and port sel_idx, input, clog2(NUM_ITEMS) bits: one-cycle product request.
REQ-011 The block SHALL have port cancel, input, 1 bit: one-cycle pulse requesting a refund.
REQ-012 The block SHALL have port price_tbl, input, NUM_ITEMS*CREDIT_W bits: item i price is in slice i; the table is sampled whenever a selection is evaluated.
REQ-013 The block SHALL have port refill, input, 1 bit: one-cycle pulse that sets all stock counters to the maximum STOCK_W value.
REQ-014 The block SHALL have port credit, output, CREDIT_W bits: current credit.
REQ-015 The block SHALL have port avail, output, NUM_ITEMS bits: bit i = idle AND credit >= price_i AND stock_i != 0.
REQ-016 The block SHALL have ports disp_valid, output, 1 bit, and disp_idx, output, clog2(NUM_ITEMS) bits: one-cycle dispense pulse with the dispensed item index.
REQ-017 The block SHALL have port change_pulse, output, 1 bit, and port change_amt, output, CREDIT_W bits: one pulse per change step with the amount returned.
REQ-018 The block SHALL have ports coin_reject, output, 1 bit, and sel_deny, output, 1 bit: one-cycle rejection pulses.
REQ-019 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, DISPENSE and CHANGE.
REQ-021 In IDLE, the block SHALL evaluate simultaneous events in priority order cancel > sel_valid > coin, with exactly one action per cycle; lower-priority events in the same cycle SHALL be dropped.
REQ-022 If multiple coin bits are set in one cycle, the block SHALL take the lowest index only.
REQ-023 For an accepted coin, if credit + value <= MAX_CREDIT, the block SHALL add the value to credit on the next edge; otherwise credit SHALL be unchanged and coin_reject SHALL pulse (no clamping). The sum SHALL be computed at CREDIT_W+1 bits.
REQ-024 For a selection of item i with credit >= price_i and stock_i != 0, the block SHALL subtract price_i from credit, decrement stock_i and go to DISPENSE; otherwise sel_deny SHALL pulse and the state SHALL remain IDLE.
REQ-025 A sel_idx >= NUM_ITEMS SHALL produce sel_deny.
REQ-026 DISPENSE SHALL last exactly 1 cycle, assert disp_valid with disp_idx, then go to CHANGE if credit != 0, else to IDLE.
REQ-027 cancel in IDLE SHALL go to CHANGE if credit != 0 and SHALL do nothing if credit == 0.
REQ-028 In CHANGE, a tick counter SHALL count 0..RETURN_TICKS-1; at terminal count the block SHALL pulse change_pulse with change_amt = min(CHANGE_UNIT, credit) and subtract that amount from credit.
REQ-029 When a change step leaves credit at 0, the FSM SHALL return to IDLE on the same edge; the tick counter SHALL clear on CHANGE entry.
REQ-030 While busy, the block SHALL ignore coin, sel_valid and cancel, and SHALL NOT pulse coin_reject or sel_deny.
REQ-031 refill SHALL be honoured in every state; a refill in the same cycle as a decrement SHALL take precedence.
REQ-032 All outputs SHALL be registered or decoded from registers only.

Reset
REQ-033 Reset SHALL set state = IDLE, credit = 0, tick counter = 0 and every stock counter = INIT_STOCK.
REQ-034 Reset SHALL set disp_valid, change_pulse, coin_reject and sel_deny to 0, and disp_idx and change_amt to 0.
REQ-035 Reset asserted mid-CHANGE SHALL discard the remaining refund without emitting a pulse.

Structure
REQ-036 A shared package SHALL hold the state enum, COIN_VALUE table {5, 10, 50} and NUM_COINS = 3.
REQ-037 The block SHALL have one sub-module, vend_change_timer: a tick counter with clear and terminal-count pulse.

Verification
REQ-038 Insert coins 50, 10, 10, 5 (credit 75), select item 0 priced 75 -> disp_valid with idx 0 for 1 cycle, credit 0, no change_pulse.
REQ-039 Insert 50 then 50 (credit 100), insert 5 -> coin_reject, credit stays 100.
REQ-040 With credit 20, cancel, RETURN_TICKS = 4 -> change_pulse with amt 5 four times, 4 cycles apart, then busy low.
REQ-041 With stock_2 = 0 and credit 100, select item 2 -> sel_deny, avail[2] = 0, credit 100; then refill and select item 2 -> dispense.
REQ-042 Pulse cancel, sel_valid and coin together with credit 30 -> refund only, and the coin is lost.
REQ-043 Assert rst during CHANGE with credit 15 -> credit 0, IDLE, no further change_pulse.
